sync_fifo_v2: RTL

Single-clock, parametrised FIFO for stream buffering between UART/SPI front-ends and processing blocks.
- Generalises the existing 16-entry FIFO: any power-of-two depth, true DEPTH-entry capacity via wrap-bit pointers, full-range fill level, almost-full/almost-empty thresholds.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Storage kept in a registered-read RAM so block RAM inference holds in both modes.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/sync_fifo_v2_if.sv | 53 +++++
 rtl/fifo_ram.sv | 32 +++
 rtl/sync_fifo_v2.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo_v2 slice: read-mode encodings and the
// helper that sizes the fill-level counter so it can represent 0..DEPTH.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Fill level needs one bit more than the address so that DEPTH itself fits.
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_v2_if.sv
// Stream-side bundle of sync_fifo_v2. The slave modport is the FIFO, the
// master modport is the producer/consumer pair around it.
// Optional macro FIFO_ERR_FLAGS_EN adds err_clr_in, overflow_out, underflow_out.
interface sync_fifo_v2_if import fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);

  localparam int FW = fill_width(DEPTH);

  logic [WIDTH-1:0] datain;
  logic             wr_in;
  logic             rd_in;
  logic [WIDTH-1:0] dataout;
  logic             dataout_valid_out;
  logic             full_out;
  logic             empty_out;
  logic             almost_full_out;
  logic             almost_empty_out;
  logic [FW-1:0]    fill_lvl_out;
`ifdef FIFO_ERR_FLAGS_EN
  logic             err_clr_in;
  logic             overflow_out;
  logic             underflow_out;

  modport slave (
    input  datain, wr_in, rd_in, err_clr_in,
    output dataout, dataout_valid_out, full_out, empty_out,
           almost_full_out, almost_empty_out, fill_lvl_out,
           overflow_out, underflow_out
  );

  modport master (
    output datain, wr_in, rd_in, err_clr_in,
    input  dataout, dataout_valid_out, full_out, empty_out,
           almost_full_out, almost_empty_out, fill_lvl_out,
           overflow_out, underflow_out
  );
`else
  modport slave (
    input  datain, wr_in, rd_in,
    output dataout, dataout_valid_out, full_out, empty_out,
           almost_full_out, almost_empty_out, fill_lvl_out
  );

  modport master (
    output datain, wr_in, rd_in,
    input  dataout, dataout_valid_out, full_out, empty_out,
           almost_full_out, almost_empty_out, fill_lvl_out
  );
`endif

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo_v2: synchronous write, registered
// read with read-enable. The array itself is never reset so it maps onto
// block RAM; only the read register clears, giving a defined dataout.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             rst_in,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the incoming word at the write address.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: capture the addressed word only when a read is requested.
  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock parametrised FIFO with wrap-bit pointers, registered fill
// level and almost flags, and a standard or first-word-fall-through read
// side. The RAM read register doubles as the FWFT head register.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module sync_fifo_v2 import fifo_pkg::*; #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic CLK,
  input  logic rst_in,
  sync_fifo_v2_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = fill_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [FW-1:0] FILL_ONE = FW'(1);
  localparam logic [FW-1:0] AF_LVL   = FW'(AFULL_THRESH);
  localparam logic [FW-1:0] AE_LVL   = FW'(AEMPTY_THRESH);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [FW-1:0]    fill, fill_next;
  logic             almost_full_q, almost_empty_q;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic             ram_re;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_acc = bus.wr_in & ~full;
  assign rd_acc = bus.rd_in & ~empty;

  // Next fill level: a simultaneous accepted read and write leave it unchanged.
  always_comb begin
    fill_next = fill;
    case ({wr_acc, rd_acc})
      2'b10:   fill_next = fill + FILL_ONE;
      2'b01:   fill_next = fill - FILL_ONE;
      default: fill_next = fill;
    endcase
  end

  // Pointers, fill level and almost flags; flags come from the next fill so
  // they change in the same cycle as fill_lvl_out.
  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill           <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      fill           <= fill_next;
      almost_full_q  <= (fill_next >= AF_LVL);
      almost_empty_q <= (fill_next <= AE_LVL);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .rst_in(rst_in),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.datain),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_STD) begin : g_std
      logic valid_q;

      assign empty     = (fill == '0);
      assign ram_re    = rd_acc;
      assign ram_raddr = rd_ptr[AW-1:0];

      // Valid pulses for the one cycle following each accepted read.
      always_ff @(posedge CLK or negedge rst_in) begin
        if (!rst_in) valid_q <= 1'b0;
        else         valid_q <= rd_acc;
      end

      assign bus.dataout_valid_out = valid_q;
    end else begin : g_fwft
      logic [PW-1:0] pf_ptr;
      logic          head_valid;
      logic          ram_has_data;
      logic          prefetch;

      assign ram_has_data = (wr_ptr != pf_ptr);
      assign prefetch     = ram_has_data & (~head_valid | rd_acc);
      assign empty        = ~head_valid;
      assign ram_re       = prefetch;
      assign ram_raddr    = pf_ptr[AW-1:0];

      // Refill the head register whenever it is empty or being consumed and
      // the RAM still holds words, so reads stream without bubbles.
      always_ff @(posedge CLK or negedge rst_in) begin
        if (!rst_in) begin
          pf_ptr     <= '0;
          head_valid <= 1'b0;
        end else begin
          if (prefetch) pf_ptr <= pf_ptr + PTR_ONE;
          head_valid <= prefetch | (head_valid & ~rd_acc);
        end
      end

      assign bus.dataout_valid_out = head_valid;
    end
  endgenerate

  assign bus.dataout          = ram_rdata;
  assign bus.full_out         = full;
  assign bus.empty_out        = empty;
  assign bus.almost_full_out  = almost_full_q;
  assign bus.almost_empty_out = almost_empty_q;
  assign bus.fill_lvl_out     = fill;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags: a refused request sets them, err_clr_in clears them,
  // and a set in the same cycle wins over the clear.
  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_in & full)      overflow_q <= 1'b1;
      else if (bus.err_clr_in)   overflow_q <= 1'b0;
      if (bus.rd_in & empty)     underflow_q <= 1'b1;
      else if (bus.err_clr_in)   underflow_q <= 1'b0;
    end
  end

  assign bus.overflow_out  = overflow_q;
  assign bus.underflow_out = underflow_q;
`endif

endmodule
